mdu_seq_mult: RTL and testbench
===============================

Name: mdu_seq_mult

Overview:
- Iterative shift-add 32x32 multiplier producing the 64-bit HI/LO pair for MULT/MULTU.
- Sits directly upstream of the 8-to-1 write-back/result select mux: hi and lo drive two of its 32-bit data inputs (in6 = hi, in7 = lo) for MFHI/MFLO.
- Exposes busy to the control path so the PC and register write can be stalled while a multiply is in flight.
- Trades the combinational array multiplier for one cycle per operand bit.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits split into hi and lo.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only when busy=0.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; latched with the operands.
- rs_val  input  WIDTH  multiplicand; latched on an accepted start.
- rt_val  input  WIDTH  multiplier; latched on an accepted start.
- hi  output  WIDTH  upper half of the last completed product.
- lo  output  WIDTH  lower half of the last completed product.
- busy  output  1  operation in progress; control stalls on it.
- done  output  1  single-cycle pulse when hi/lo have just been updated.

Behaviour:
- Reset (synchronous, active-high, priority over everything): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, accumulator=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start=1, latch operands and is_signed, clear the 2*WIDTH accumulator, set counter=0, go to RUN. Otherwise stay in IDLE.
  - RUN: each cycle, if multiplier LSB=1, add the multiplicand magnitude (shifted by the counter) into the accumulator. Then shift the multiplier right and increment the counter. When the counter reaches WIDTH-1 on this edge, go to DONE and write the final product to hi/lo.
  - DONE: lasts exactly one cycle. Same start rules as IDLE: start=1 begins a new operation and goes to RUN; otherwise go to IDLE.
- Outputs by state:
  - busy=1 only in RUN.
  - done=1 only in DONE.
- Latency: start sampled at edge E0 leads to RUN for WIDTH edges. hi/lo update and done=1 occur in the cycle after edge E0+WIDTH, which is 32 cycles for WIDTH=32.
- Signed handling:
  - When is_signed=1, operands are converted to magnitudes at latch time; 0x80000000 maps to magnitude 0x80000000.
  - The product is negated (two's complement over 2*WIDTH bits) at the final write if the operand sign bits differ.
- Unsigned handling: operands are used as-is.
- hi/lo are written only at completion and otherwise hold. During RUN they keep the previous result, so the downstream mux always sees stable values.
- start while busy=1 is ignored: no relatch and no restart.
- Reset mid-RUN aborts the operation and clears hi/lo to 0. No done pulse is produced for the aborted operation.
- Operand inputs may change freely after an accepted start.
- A zero operand still takes the full latency; there is no early-out.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10).
- Also in the package: the MDU operand width constant shared with the datapath.
- One natural sub-module, mdu_abs_neg. It is combinational: conditional two's-complement magnitude/negate, parameterised by width. It is instantiated for each operand at WIDTH and for the product at 2*WIDTH.
- FSM, counter and accumulator live in mdu_seq_mult.

Test Plan:
- Unsigned small: start with is_signed=0, rs=3, rt=5 -> done pulse 32 cycles after the start edge; hi=0x00000000, lo=0x0000000F; busy=1 for exactly 32 cycles.
- Unsigned max: rs=rt=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed mixed: rs=0xFFFFFFFE (-2), rt=3, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. Then rs=rt=0x80000000 signed -> hi=0x40000000, lo=0x00000000.
- Ignored start and hold: a second start with new operands at cycle 10 of RUN is ignored, and the first result is unchanged. hi/lo keep the previous result throughout RUN until done.
- Back-to-back: start asserted in the DONE cycle with rs=7, rt=6 -> busy=1 on the next cycle, second done 32 cycles later with lo=0x0000002A. The first result is visible on hi/lo during the intervening run.
- Reset mid-op: reset=1 at cycle 15 of RUN -> next cycle state IDLE, busy=0, hi=lo=0, no done pulse. A subsequent start runs normally.

Source files
------------

// File: rtl/mdu_seq_mult_pkg.sv
// Shared definitions for the multiply/divide unit datapath.
//   mdu_state_t : sequencer state encoding (IDLE / RUN / DONE)
//   MDU_WIDTH   : operand width shared with the datapath
package mdu_seq_mult_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_t;

endpackage

// File: rtl/mdu_seq_mult_abs_neg.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of the final product.
//   a   : input value
//   neg : 1 = output -a, 0 = pass a through
//   y   : result (same width; the most negative value maps to itself)
module mdu_abs_neg #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  always_comb begin
    y = neg ? (~a + W'(1)) : a;
  end

endmodule

// File: rtl/mdu_seq_mult.sv
// Iterative shift-add multiplier for MULT/MULTU. One multiplier bit is
// consumed per cycle; hi/lo hold the last completed product and only
// change on completion, so the downstream result mux sees stable data.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start           : begin a multiply (ignored while busy)
//   is_signed       : 1 = MULT, 0 = MULTU
//   rs_val, rt_val  : multiplicand / multiplier, latched on accepted start
//   hi, lo          : upper / lower halves of the last product
//   busy            : high while the multiply is running
//   done            : one-cycle pulse after hi/lo are updated
module mdu_seq_mult
  import mdu_seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  mdu_state_t state, state_nxt;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [CNT_W-1:0]   cnt;
  logic               neg_res;
  logic               last;
  logic               accept;

  mdu_abs_neg #(.W(WIDTH)) u_abs_rs (
    .a   (rs_val),
    .neg (is_signed & rs_val[WIDTH-1]),
    .y   (rs_mag)
  );

  mdu_abs_neg #(.W(WIDTH)) u_abs_rt (
    .a   (rt_val),
    .neg (is_signed & rt_val[WIDTH-1]),
    .y   (rt_mag)
  );

  // The final edge writes hi/lo directly from this cycle's partial sum,
  // so the sign fix-up is applied to acc_nxt rather than acc.
  mdu_abs_neg #(.W(2*WIDTH)) u_neg_prod (
    .a   (acc_nxt),
    .neg (neg_res),
    .y   (product)
  );

  always_comb begin
    acc_nxt = acc + (mplr[0] ? mcand : '0);
    last    = (cnt == CNT_W'(WIDTH-1));
    accept  = start && (state != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = start ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, rs_mag};
      mplr    <= rt_mag;
      cnt     <= '0;
      neg_res <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
    end else if (state == ST_RUN) begin
      acc   <= acc_nxt;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        hi <= product[2*WIDTH-1:WIDTH];
        lo <= product[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq_mult.sv
module tb_mdu_seq_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  mdu_seq_mult #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive start for one edge, then scramble the operand inputs.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = sgn;
    rs_val    = a;
    rt_val    = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    rs_val    = $urandom;
    rt_val    = $urandom;
    is_signed = 1'($urandom_range(1, 0));
  endtask

  // Called just after the accepting edge. Counts busy cycles until done,
  // verifies hi/lo hold the previous result meanwhile, optionally injects
  // a start at busy cycle 'inj'. Returns with the bench in the DONE cycle.
  task automatic run_check(input string nm, input logic [31:0] eh,
                           input logic [31:0] el, input int inj);
    int bc;
    bit seen;
    bit hold_ok;
    bc = 0;
    seen = 0;
    hold_ok = 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1;
      else begin
        if (busy) bc++;
        if (hi !== prev_hi || lo !== prev_lo) hold_ok = 0;
        if (inj > 0 && bc == inj) begin
          start  = 1'b1;
          rs_val = 32'h0000_0001;
          rt_val = 32'h0000_0001;
        end
      end
    end
    start = 1'b0;
    chk({nm, " done_seen"}, 64'(seen), 64'd1);
    chk({nm, " busy_cycles"}, 64'(bc), 64'd32);
    chk({nm, " hold_during_run"}, 64'(hold_ok), 64'd1);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    prev_hi = eh;
    prev_lo = el;
  endtask

  task automatic after_done(input string nm);
    @(negedge clk);
    chk({nm, " done_single"}, 64'({done, busy}), 64'd0);
  endtask

  initial begin
    vecs[0] = '{"u_3x5",      1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{"u_max",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{"s_m2x3",     1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[3] = '{"s_minxmin",  1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[4] = '{"s_m1xm1",    1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[5] = '{"s_minx1",    1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[6] = '{"u_zero",     1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{"u_bigx2",    1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[8] = '{"s_7xm1",     1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi",   64'(hi),   64'd0);
    chk("reset lo",   64'(lo),   64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      run_check(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo, 0);
      after_done(vecs[i].name);
    end

    // Start during RUN must be ignored: 100*200 = 20000.
    launch(1'b0, 32'd100, 32'd200);
    run_check("ignored_start", 32'h0, 32'h0000_4E20, 10);
    after_done("ignored_start");

    // Back-to-back: new start in the DONE cycle.
    launch(1'b0, 32'h1234_5678, 32'h0000_0010);
    run_check("b2b_first", 32'h0000_0001, 32'h2345_6780, 0);
    is_signed = 1'b0; rs_val = 32'd7; rt_val = 32'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    run_check("b2b_second", 32'h0, 32'h0000_002A, 0);
    after_done("b2b_second");

    // Reset in the middle of a run.
    launch(1'b1, 32'hFFFF_FFFE, 32'h0000_0003);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    chk("midreset hi",   64'(hi),   64'd0);
    chk("midreset lo",   64'(lo),   64'd0);
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done || busy) seen_done++;
      end
      chk("midreset no_done", 64'(seen_done), 64'd0);
    end
    prev_hi = '0;
    prev_lo = '0;
    launch(1'b0, 32'd9, 32'd9);
    run_check("post_reset", 32'h0, 32'h0000_0051, 0);
    after_done("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
